// File: rtl/ifft64_sched.sv
// ifft64_sched: symbol-level two-requester arbiter sharing one ifft64, with a tag FIFO naming each output symbol's owner.
// Define IFFT64_SCHED_STRICT_PRI_EN for strict requester-0 priority; default build is round-robin.
module ifft64_sched #(
    parameter int DWIDTH    = 16,
    parameter int TAG_DEPTH = 4,
    parameter int SYM_LEN   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] s0_re,
    input  logic [DWIDTH-1:0] s0_im,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [DWIDTH-1:0] s1_re,
    input  logic [DWIDTH-1:0] s1_im,
    input  logic              s1_valid,
    output logic              s1_ready,
    output logic [DWIDTH-1:0] fft_in_re,
    output logic [DWIDTH-1:0] fft_in_im,
    output logic              fft_in_valid,
    input  logic              fft_in_ready,
    input  logic [DWIDTH+7:0] fft_out_re,
    input  logic [DWIDTH+7:0] fft_out_im,
    input  logic              fft_out_valid,
    output logic              fft_out_ready,
    output logic [DWIDTH+7:0] out_re,
    output logic [DWIDTH+7:0] out_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_tag,
    output logic              out_last,
    output logic              err
);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);
    localparam logic [5:0]    LAST_IDX = 6'(SYM_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [5:0]    in_cnt_q, in_cnt_d;
    logic [5:0]    out_cnt_q, out_cnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic          err_q, err_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          tag_mem_q [TAG_DEPTH];

    logic in_beat, out_beat, fifo_empty, push, pop;

    assign in_beat    = fft_in_valid & fft_in_ready;
    assign out_beat   = out_valid & out_ready;
    assign fifo_empty = (count_q == '0);
    assign push       = in_beat & (in_cnt_q == LAST_IDX);
    assign pop        = out_beat & (out_cnt_q == LAST_IDX) & ~fifo_empty;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        fft_in_re    = '0;
        fft_in_im    = '0;
        fft_in_valid = 1'b0;
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;
        case (state_q)
            ST_GNT0: begin
                fft_in_re    = s0_re;
                fft_in_im    = s0_im;
                fft_in_valid = s0_valid;
                s0_ready     = fft_in_ready;
            end
            ST_GNT1: begin
                fft_in_re    = s1_re;
                fft_in_im    = s1_im;
                fft_in_valid = s1_valid;
                s1_ready     = fft_in_ready;
            end
            default: ;
        endcase
    end

    assign out_re        = fft_out_re;
    assign out_im        = fft_out_im;
    assign out_valid     = fft_out_valid;
    assign fft_out_ready = out_ready;
    assign out_tag       = fifo_empty ? 1'b0 : tag_mem_q[rd_ptr_q];
    assign out_last      = out_valid & (out_cnt_q == LAST_IDX);
    assign err           = err_q;

    // A grant lasts a whole symbol; arbitration only happens from IDLE, and only with FIFO room.
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q < FULL_CNT) begin
`ifdef IFFT64_SCHED_STRICT_PRI_EN
                    if (s0_valid)      state_d = ST_GNT0;
                    else if (s1_valid) state_d = ST_GNT1;
`else
                    if (s0_valid && s1_valid) state_d = last_gnt_q ? ST_GNT0 : ST_GNT1;
                    else if (s0_valid)        state_d = ST_GNT0;
                    else if (s1_valid)        state_d = ST_GNT1;
`endif
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (in_beat) begin
                    in_cnt_d = in_cnt_q + 6'd1;
                    if (in_cnt_q == LAST_IDX) begin
                        state_d    = ST_IDLE;
                        last_gnt_d = (state_q == ST_GNT1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_cnt_d = out_beat ? out_cnt_q + 6'd1 : out_cnt_q;
        err_d     = err_q | (out_beat & fifo_empty);
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            last_gnt_q <= 1'b1;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: tag storage is not reset; entries are only read while count_q marks them as written.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= (state_q == ST_GNT1);
    end

endmodule

// File: tb/tb_ifft64_sched.sv
// Directed bench for ifft64_sched with a behavioural ifft64 stub (always ready, fixed 80-cycle echo).
module tb_ifft64_sched;
    localparam int DW  = 16;
    localparam int OW  = DW + 8;
    localparam int TD  = 2;
    localparam int LAT = 80;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s0_re = '0, s0_im = '0, s1_re = '0, s1_im = '0;
    logic          s0_valid = 1'b0, s1_valid = 1'b0;
    logic          s0_ready, s1_ready;
    logic [DW-1:0] fft_in_re, fft_in_im;
    logic          fft_in_valid;
    logic          fft_in_ready = 1'b1;
    logic [OW-1:0] fft_out_re = '0, fft_out_im = '0;
    logic          fft_out_valid = 1'b0;
    logic          fft_out_ready;
    logic [OW-1:0] out_re, out_im;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_tag, out_last, err;

    always #5 clk = ~clk;

    ifft64_sched #(.DWIDTH(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .s0_re(s0_re), .s0_im(s0_im), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_re(s1_re), .s1_im(s1_im), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .fft_in_re(fft_in_re), .fft_in_im(fft_in_im),
        .fft_in_valid(fft_in_valid), .fft_in_ready(fft_in_ready),
        .fft_out_re(fft_out_re), .fft_out_im(fft_out_im),
        .fft_out_valid(fft_out_valid), .fft_out_ready(fft_out_ready),
        .out_re(out_re), .out_im(out_im), .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_last(out_last), .err(err)
    );

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int            due;
    } ifft_item_t;

    ifft_item_t ifq[$];
    int         gnt_log[$];

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    bit src_en[2];
    int s_idx[2];
    int in_beats = 0, sym_in = 0, out_beats = 0, out_sym = 0;
    int gnt_ob = 0, stop_at = -1;
    bit out_rdy = 1'b0, orphan = 1'b0, drop_arm = 1'b0, trk_gap = 1'b0, err_exp = 1'b0;
    int orphan_k = 0, drop_left = 0, gap_cnt = 0, last_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, let it settle, then score what the next rising edge will take.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s0_valid     = !rst && src_en[0];
        s1_valid     = !rst && src_en[1] && (drop_left == 0);
        s0_re        = DW'(32'h0100 + s_idx[0] % 64);
        s0_im        = ~s0_re;
        s1_re        = DW'(32'h0200 + s_idx[1] % 64);
        s1_im        = ~s1_re;
        fft_in_ready = 1'b1;
        out_ready    = out_rdy;
        if (rst || !(orphan || (ifq.size() > 0 && cyc >= ifq[0].due))) begin
            fft_out_valid = 1'b0;
            fft_out_re    = '0;
            fft_out_im    = '0;
        end else if (orphan) begin
            fft_out_valid = 1'b1;
            fft_out_re    = '0;
            fft_out_im    = '0;
        end else begin
            fft_out_valid = 1'b1;
            fft_out_re    = {{8{ifq[0].re[DW-1]}}, ifq[0].re};
            fft_out_im    = {{8{ifq[0].im[DW-1]}}, ifq[0].im};
        end
        #1;
        if (rst) begin
            ifq.delete();
            sym_in    = 0;
            out_sym   = 0;
            drop_left = 0;
        end else begin
            if (drop_left > 0) begin
                check("drop_s0_ready", s0_ready, 0);
                check("drop_s1_ready", s1_ready, 1);
                check("drop_fft_valid", fft_in_valid, 0);
                drop_left--;
            end
            if (fft_in_valid && fft_in_ready) begin
                int r;
                logic [DW-1:0] er, ei;
                r  = s1_ready ? 1 : 0;
                er = r ? s1_re : s0_re;
                ei = r ? s1_im : s0_im;
                check("one_grant", {s0_ready, s1_ready}, r ? 2'b01 : 2'b10);
                check("fft_in_re", fft_in_re, er);
                check("fft_in_im", fft_in_im, ei);
                if (sym_in == 0) begin
                    gnt_log.push_back(r);
                    gnt_ob = out_beats;
                end
                ifq.push_back('{re: er, im: ei, due: cyc + LAT});
                s_idx[r]++;
                sym_in = (sym_in + 1) % 64;
                in_beats++;
                if (drop_arm && r == 1 && sym_in == 20) begin
                    drop_arm  = 1'b0;
                    drop_left = 10;
                end
                if (in_beats == stop_at) begin
                    src_en[0] = 1'b0;
                    src_en[1] = 1'b0;
                end
            end else if (trk_gap && s0_valid && in_beats > 0) begin
                gap_cnt++;
            end
            if (out_valid && out_ready) begin
                if (orphan) begin
                    check("orph_tag", out_tag, 0);
                    check("orph_last", out_last, orphan_k == 63);
                    check("orph_err", err, orphan_k > 0);
                    orphan_k++;
                end else begin
                    check("out_re", out_re, {{8{ifq[0].re[DW-1]}}, ifq[0].re});
                    check("out_tag", out_tag, ifq[0].re[9]);
                    check("out_last", out_last, out_sym == 63);
                    check("out_err", err, err_exp);
                    if (out_last) last_cnt++;
                    void'(ifq.pop_front());
                    out_sym = (out_sym + 1) % 64;
                    out_beats++;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s0_ready"}, s0_ready, 0);
        check({tag, "_s1_ready"}, s1_ready, 0);
        check({tag, "_fft_in_valid"}, fft_in_valid, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_tag"}, out_tag, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_en[0] = 1'b0;
        src_en[1] = 1'b0;
        tick();
        tick();
        check_all_zero("in_rst");
        rst     = 1'b0;
        err_exp = 1'b0;
        tick();
        check_all_zero("post_rst");
    endtask

    task automatic run_to(input int target, input int limit);
        for (int i = 0; i < limit && in_beats < target; i++) tick();
        check("in_beats_reached", in_beats >= target, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 1500 && ifq.size() > 0; i++) tick();
        repeat (3) tick();
        check("drained", ifq.size(), 0);
    endtask

    initial begin
        int base, ob_base, in_base;
        do_reset();

        // Requester 0 alone: two symbols, one IDLE gap between them, tags 0, last on 63/127.
        out_rdy = 1'b1;
        trk_gap = 1'b1;
        stop_at = 128;
        src_en[0] = 1'b1;
        run_to(128, 400);
        drain();
        trk_gap = 1'b0;
        check("t1_gap_cycles", gap_cnt, 1);
        check("t1_last_count", last_cnt, 2);
        check("t1_out_beats", out_beats, 128);
        check("t1_grants", gnt_log.size(), 2);

        // Both requesters continuously for four symbols.
        do_reset();
        gnt_log.delete();
        stop_at   = in_beats + 256;
        src_en[0] = 1'b1;
        src_en[1] = 1'b1;
        run_to(stop_at, 1500);
        drain();
        check("t2_grants", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef IFFT64_SCHED_STRICT_PRI_EN
            check("t2_order", gnt_log[i], 0);
`else
            check("t2_order", gnt_log[i], i % 2);
`endif
        end

        // Requester 1 pauses 10 cycles at sample 20 while requester 0 waits.
        gnt_log.delete();
        base      = s_idx[1];
        drop_arm  = 1'b1;
        stop_at   = in_beats + 128;
        src_en[1] = 1'b1;
        for (int i = 0; i < 20 && s_idx[1] == base; i++) tick();
        src_en[0] = 1'b1;
        run_to(stop_at, 1000);
        drain();
        check("t3_drop_seen", drop_arm, 0);
        check("t3_s1_beats", s_idx[1] - base, 64);
        check("t3_grants", gnt_log.size(), 2);
        check("t3_first", gnt_log[0], 1);
        check("t3_second", gnt_log[1], 0);

        // FIFO full with output stalled: no third grant until one symbol drains.
        gnt_log.delete();
        ob_base   = out_beats;
        in_base   = in_beats;
        out_rdy   = 1'b0;
        stop_at   = in_base + 192;
        src_en[0] = 1'b1;
        run_to(in_base + 128, 400);
        repeat (100) tick();
        check("t4_held_beats", in_beats - in_base, 128);
        check("t4_s0_ready", s0_ready, 0);
        check("t4_s1_ready", s1_ready, 0);
        check("t4_fft_valid", fft_in_valid, 0);
        out_rdy = 1'b1;
        run_to(stop_at, 800);
        check("t4_grants", gnt_log.size(), 3);
        check("t4_gnt_after_pop", gnt_ob - ob_base, 65);
        drain();

        // Orphan output symbol with an empty FIFO.
        orphan   = 1'b1;
        orphan_k = 0;
        for (int i = 0; i < 100 && orphan_k < 64; i++) tick();
        orphan  = 1'b0;
        err_exp = 1'b1;
        check("t5_orphan_beats", orphan_k, 64);
        repeat (5) tick();
        check("t5_err_sticky", err, 1);
        check("t5_tag_empty", out_tag, 0);

        // Reset at input sample 30 aborts the symbol; a fresh symbol then runs cleanly.
        src_en[0] = 1'b1;
        for (int i = 0; i < 200 && sym_in < 30; i++) tick();
        check("t6_at_30", sym_in, 30);
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        err_exp = 1'b0;
        tick();
        check_all_zero("t6_after_rst");
        gnt_log.delete();
        ob_base = out_beats;
        stop_at = in_beats + 64;
        run_to(stop_at, 300);
        drain();
        check("t6_out_beats", out_beats - ob_base, 64);
        check("t6_grant", gnt_log.size(), 1);
        check("t6_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
